// File: rtl/rrf_alloc_ctrl.sv
// rtl/rrf_alloc_ctrl.sv - rename-register/ROB ring allocation controller with mispredict recovery
module rrf_alloc_ctrl #(
    parameter int RRF_NUM     = 64,
    parameter int RRF_SEL     = 6,
    parameter int RECOVER_CYC = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req1,
    input  logic               req2,
    input  logic [1:0]         comnum,
    input  logic [RRF_SEL-1:0] comptr,
    input  logic               prmiss,
    output logic               stall,
    output logic               dp1,
    output logic               dp2,
    output logic [RRF_SEL-1:0] dp1_addr,
    output logic [RRF_SEL-1:0] dp2_addr,
    output logic [RRF_SEL-1:0] dispatchptr,
    output logic [RRF_SEL:0]   rrf_freenum,
    output logic               recovering,
    output logic               err_proto,
    output logic               err_ovf
);

    typedef enum logic {RUN, RECOVER} state_t;

    localparam logic [RRF_SEL:0] FULL     = (RRF_SEL+1)'(RRF_NUM);
    localparam logic [3:0]       CNT_INIT = 4'(RECOVER_CYC - 1);

    state_t           state;
    logic [3:0]       cnt;
    logic [1:0]       need;
    logic [1:0]       alloc;
    logic [RRF_SEL:0] occupied;
    logic [RRF_SEL+1:0] sum;
    logic             ovf;

    assign need  = {1'b0, req1} + {1'b0, req1 & req2};
    assign stall = prmiss | (state == RECOVER)
                 | ({{(RRF_SEL-1){1'b0}}, need} > rrf_freenum);
    assign dp1   = req1 & ~stall;
    assign dp2   = req1 & req2 & ~stall;
    assign alloc = {1'b0, dp1} + {1'b0, dp2};

    assign dp1_addr = dispatchptr;
    assign dp2_addr = dispatchptr + RRF_SEL'(1);

    // Grant only ever consumes registered free entries, so free - alloc never underflows.
    assign occupied = FULL - rrf_freenum;
    assign ovf      = {{(RRF_SEL-1){1'b0}}, comnum} > occupied;
    assign sum      = {1'b0, rrf_freenum} - {{RRF_SEL{1'b0}}, alloc}
                    + {{RRF_SEL{1'b0}}, comnum};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= '0;
            dispatchptr <= '0;
            rrf_freenum <= FULL;
            recovering  <= 1'b0;
            err_proto   <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            if (req2 && !req1)
                err_proto <= 1'b1;
            if (prmiss) begin
                state       <= RECOVER;
                recovering  <= 1'b1;
                cnt         <= CNT_INIT;
                dispatchptr <= comptr;
                rrf_freenum <= FULL;
            end else if (state == RECOVER) begin
                // Follow the commit pointer until restart; commits are implied by the flush.
                dispatchptr <= comptr;
                rrf_freenum <= FULL;
                if (cnt == 4'd0) begin
                    state      <= RUN;
                    recovering <= 1'b0;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end else begin
                dispatchptr <= dispatchptr + {{(RRF_SEL-2){1'b0}}, alloc};
                rrf_freenum <= (sum > {1'b0, FULL}) ? FULL : sum[RRF_SEL:0];
                if (ovf)
                    err_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rrf_alloc_ctrl.sv
// tb/tb_rrf_alloc_ctrl.sv - directed self-checking bench for rrf_alloc_ctrl
module tb_rrf_alloc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req1, req2, prmiss;
    logic [1:0] comnum;
    logic [5:0] comptr;
    logic       stall, dp1, dp2, recovering, err_proto, err_ovf;
    logic [5:0] dp1_addr, dp2_addr, dispatchptr;
    logic [6:0] rrf_freenum;

    int n_tests = 0;
    int n_fail  = 0;

    rrf_alloc_ctrl #(.RRF_NUM(64), .RRF_SEL(6), .RECOVER_CYC(2)) dut (
        .clk(clk), .reset(reset), .req1(req1), .req2(req2), .comnum(comnum),
        .comptr(comptr), .prmiss(prmiss), .stall(stall), .dp1(dp1), .dp2(dp2),
        .dp1_addr(dp1_addr), .dp2_addr(dp2_addr), .dispatchptr(dispatchptr),
        .rrf_freenum(rrf_freenum), .recovering(recovering),
        .err_proto(err_proto), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r1, input logic r2, input logic [1:0] cn, input logic pm);
        req1 = r1; req2 = r2; comnum = cn; prmiss = pm;
        #1;
    endtask

    initial begin
        reset = 1'b1; comptr = 6'd0;
        drive(1'b0, 1'b0, 2'd0, 1'b1);
        tick(); tick();
        chk("rst_recovering_over_prmiss", 32'(recovering), 32'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        chk("rst_ptr", 32'(dispatchptr), 32'd0);
        chk("rst_free", 32'(rrf_freenum), 32'd64);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dp1", 32'(dp1), 32'd0);
        chk("rst_errs", 32'({err_proto, err_ovf}), 32'd0);

        // Fill the ring two at a time
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b1, 2'd0, 1'b0);
            chk("fill_dp", 32'({dp1, dp2, stall}), 32'b110);
            chk("fill_ptr", 32'(dispatchptr), 32'(2*i));
            chk("fill_free", 32'(rrf_freenum), 32'(64-2*i));
            tick();
        end
        drive(1'b1, 1'b1, 2'd0, 1'b0);
        chk("full_free", 32'(rrf_freenum), 32'd0);
        chk("full_ptr", 32'(dispatchptr), 32'd0);
        chk("full_stall", 32'({stall, dp1, dp2}), 32'b100);

        // Same-cycle commit is not usable for grant
        drive(1'b1, 1'b0, 2'd2, 1'b0);
        chk("samecyc_stall", 32'({stall, dp1}), 32'b10);
        tick();
        drive(1'b1, 1'b0, 2'd0, 1'b0);
        chk("samecyc_free_next", 32'(rrf_freenum), 32'd2);
        chk("samecyc_grant_next", 32'({stall, dp1}), 32'b01);
        tick();
        chk("one_free", 32'(rrf_freenum), 32'd1);
        drive(1'b1, 1'b1, 2'd0, 1'b0);
        chk("one_free_pair_stall", 32'({stall, dp1, dp2}), 32'b100);
        drive(1'b1, 1'b0, 2'd0, 1'b0);
        chk("one_free_single", 32'({stall, dp1, dp2}), 32'b010);
        tick();
        chk("one_free_after_free", 32'(rrf_freenum), 32'd0);
        chk("one_free_after_ptr", 32'(dispatchptr), 32'd2);

        // Free 10 entries, then walk the pointer to 63 at constant occupancy
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 2'd2, 1'b0);
            tick();
        end
        for (int i = 0; i < 61; i++) begin
            drive(1'b1, 1'b0, 2'd1, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 2'd0, 1'b0);
        chk("wrap_pre_ptr", 32'(dispatchptr), 32'd63);
        chk("wrap_pre_free", 32'(rrf_freenum), 32'd10);
        chk("wrap_dp1_addr", 32'(dp1_addr), 32'd63);
        chk("wrap_dp2_addr", 32'(dp2_addr), 32'd0);
        chk("wrap_grant", 32'({dp1, dp2}), 32'b11);
        tick();
        chk("wrap_ptr", 32'(dispatchptr), 32'd1);
        chk("wrap_free", 32'(rrf_freenum), 32'd8);

        // Mispredict: 3 stalled cycles then grant at comptr
        comptr = 6'd17;
        drive(1'b1, 1'b0, 2'd2, 1'b1);
        chk("pm_c0_stall", 32'({stall, dp1}), 32'b10);
        tick();
        drive(1'b1, 1'b0, 2'd0, 1'b0);
        chk("pm_c1_stall", 32'({stall, dp1, recovering}), 32'b101);
        chk("pm_c1_ptr", 32'(dispatchptr), 32'd17);
        chk("pm_c1_free", 32'(rrf_freenum), 32'd64);
        tick();
        chk("pm_c2_stall", 32'({stall, dp1, recovering}), 32'b101);
        tick();
        chk("pm_c3_grant", 32'({stall, dp1, recovering}), 32'b010);
        chk("pm_c3_addr", 32'(dp1_addr), 32'd17);
        chk("pm_c3_free", 32'(rrf_freenum), 32'd64);

        // Second prmiss inside RECOVER restarts the hold
        comptr = 6'd30;
        drive(1'b1, 1'b0, 2'd0, 1'b1);
        tick();
        comptr = 6'd40;
        drive(1'b1, 1'b0, 2'd0, 1'b1);
        chk("pm2_first_hold", 32'(stall), 32'd1);
        tick();
        drive(1'b1, 1'b0, 2'd0, 1'b0);
        chk("pm2_c1_stall", 32'(stall), 32'd1);
        chk("pm2_c1_ptr", 32'(dispatchptr), 32'd40);
        tick();
        chk("pm2_c2_stall", 32'(stall), 32'd1);
        tick();
        chk("pm2_c3_grant", 32'({stall, dp1}), 32'b01);
        chk("pm2_c3_addr", 32'(dp1_addr), 32'd40);
        tick();
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        chk("pm2_after_ptr", 32'(dispatchptr), 32'd41);
        chk("pm2_after_free", 32'(rrf_freenum), 32'd63);

        // Protocol error: req2 without req1
        drive(1'b0, 1'b1, 2'd0, 1'b0);
        chk("proto_nogrant", 32'({stall, dp1, dp2}), 32'b000);
        chk("proto_pre", 32'(err_proto), 32'd0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        chk("proto_set", 32'(err_proto), 32'd1);
        tick();
        chk("proto_sticky", 32'(err_proto), 32'd1);
        chk("proto_ptr_unmoved", 32'(dispatchptr), 32'd41);

        // Over-free: 2 commits with only 1 occupied
        chk("ovf_pre", 32'(err_ovf), 32'd0);
        drive(1'b0, 1'b0, 2'd2, 1'b0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        chk("ovf_set", 32'(err_ovf), 32'd1);
        chk("ovf_sat", 32'(rrf_freenum), 32'd64);
        tick();
        chk("ovf_sticky", 32'(err_ovf), 32'd1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst2_errs", 32'({err_proto, err_ovf}), 32'd0);
        chk("rst2_ptr", 32'(dispatchptr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
